alu_arbiter: RTL

Shares one combinational ALU between two requesters. Each requester presents operands plus ALUsel/ALUop over a valid/ready handshake, and the block arbitrates between them. It registers the operands onto the ALU, samples the result and flags after one execute cycle, and returns them on a per-requester response handshake. It sits between the instruction-side and address-side issuers and the shared `ALU` in the datapath.

---
 rtl/alu_arbiter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
// Arbitrates the two request channels, registers the winning operands onto
// the ALU, samples the result and flags after one execute cycle and returns
// them on the winner's response handshake.
//
// Build option: define ALU_ARB_FIXED_PRIO_EN for fixed priority (req0 always
// wins); otherwise arbitration is round-robin.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   reqN_valid/ready              request handshake, N in {0,1}
//   reqN_a/b/sel/op               request operands, ALUsel and ALUop
//   rspN_valid/ready              response handshake, N in {0,1}
//   rsp_result/carry/zero/sign    registered ALU result and flags, shared
//   alu_a/b/sel/op                registered operands to the ALU
//   alu_result/carry/zero/sign    result and flags from the ALU
module alu_arbiter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_sel,
  input  logic [4:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_sel,
  input  logic [4:0]       req1_op,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_carry,
  output logic             rsp_zero,
  output logic             rsp_sign,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_sel,
  output logic [4:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry,
  input  logic             alu_zero,
  input  logic             alu_sign
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  logic   grant;     // requester owning the operation in flight
  logic   win1;      // arbitration picks req1 this cycle
  logic   rsp_hs;    // response handshake for the granted requester

`ifndef ALU_ARB_FIXED_PRIO_EN
  logic   last_grant;
`endif

  // Arbitration winner among the asserted valids
  always_comb begin
    win1 = 1'b0;
`ifdef ALU_ARB_FIXED_PRIO_EN
    win1 = req1_valid & ~req0_valid;
`else
    if (req0_valid && req1_valid) begin
      win1 = ~last_grant;
    end else begin
      win1 = req1_valid & ~req0_valid;
    end
`endif
  end

  // Ready is combinational and only offered in IDLE
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (state == IDLE) begin
      req0_ready = req0_valid & ~win1;
      req1_ready = win1;
    end
  end

  assign rsp_hs = grant ? (rsp1_valid & rsp1_ready) : (rsp0_valid & rsp0_ready);

  // Control FSM with registered ALU-side and response-side outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_grant <= 1'b1;
`endif
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
      rsp_zero   <= 1'b0;
      rsp_sign   <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_sel    <= 1'b0;
      alu_op     <= 5'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req0_ready || req1_ready) begin
            alu_a   <= win1 ? req1_a   : req0_a;
            alu_b   <= win1 ? req1_b   : req0_b;
            alu_sel <= win1 ? req1_sel : req0_sel;
            alu_op  <= win1 ? req1_op  : req0_op;
            grant   <= win1;
            state   <= EXEC;
          end
        end
        EXEC: begin
          rsp_result <= alu_result;
          rsp_carry  <= alu_carry;
          rsp_zero   <= alu_zero;
          rsp_sign   <= alu_sign;
          if (grant) begin
            rsp1_valid <= 1'b1;
          end else begin
            rsp0_valid <= 1'b1;
          end
          state <= RESP;
        end
        RESP: begin
          if (rsp_hs) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_grant <= grant;
`endif
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
